// File: rtl/ara_vcfg_unit.sv
// RVV configuration unit: executes vsetvli/vsetivli/vsetvl and owns the vl, vtype and vstart CSRs.
// Operands are captured on accept, vl/vtype are computed in CALC, and the result is held in RESP until taken.
module ara_vcfg_unit #(
  parameter int unsigned VLEN = 4096,
  parameter int unsigned ELEN = 64,
  parameter int unsigned XLEN = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [31:0]               req_instr_i,
  input  logic [XLEN-1:0]           req_rs1_i,
  input  logic [XLEN-1:0]           req_rs2_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [XLEN-1:0]           resp_rd_data_o,
  output logic                      resp_illegal_o,
  input  logic                      vstart_we_i,
  input  logic [$clog2(VLEN)-1:0]   vstart_wdata_i,
  output logic [$clog2(VLEN):0]     vl_o,
  output logic [8:0]                vtype_o,
  output logic [$clog2(VLEN)-1:0]   vstart_o,
  output logic [XLEN-1:0]           vlenb_o
);
  localparam int unsigned VSW = $clog2(VLEN);
  localparam int unsigned VLW = VSW + 1;
  localparam logic [VLW-1:0] VLEN_L = VLW'(VLEN);
  localparam logic [10:0]    ELEN_L = 11'(ELEN);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e          state_q;
  logic            req_ready_q, resp_valid_q, resp_illegal_q;
  logic [XLEN-1:0] resp_rd_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [VLW-1:0]  vl_q;
  logic [7:0]      vtype_q;
  logic            vill_q;
  logic [VSW-1:0]  vstart_q;

  logic            is_cfg, is_vsetvli, is_vsetivli, is_vsetvl, legal_d;
  logic            rd_x0, rs1_x0, keep_vl;
  logic [XLEN-1:0] vtype_raw, avl;
  logic [2:0]      vlmul, vsew, fshift;
  logic            frac, vill_d;
  logic [10:0]     sew_w;
  logic [VLW-1:0]  vlmax_base, vlmax, vl_d;

  assign is_cfg      = (instr_q[6:0] == 7'h57) && (instr_q[14:12] == 3'b111);
  assign is_vsetvli  = ~instr_q[31];
  assign is_vsetivli = (instr_q[31:30] == 2'b11);
  assign is_vsetvl   = (instr_q[31:25] == 7'b1000000);
  assign legal_d     = is_cfg && (is_vsetvli || is_vsetivli || is_vsetvl);
  assign rd_x0       = (instr_q[11:7] == 5'd0);
  assign rs1_x0      = (instr_q[19:15] == 5'd0);
  assign keep_vl     = !is_vsetivli && rs1_x0 && rd_x0;

  always_comb begin
    vtype_raw = '0;
    if (is_vsetvl)        vtype_raw = rs2_q;
    else if (is_vsetivli) vtype_raw[9:0] = instr_q[29:20];
    else                  vtype_raw[10:0] = instr_q[30:20];
  end

  // Fractional encodings 101/110/111 mean LMUL = 1/8, 1/4, 1/2.
  assign vlmul  = vtype_raw[2:0];
  assign vsew   = vtype_raw[5:3];
  assign frac   = vlmul[2];
  assign fshift = 3'd4 - {1'b0, vlmul[1:0]};
  assign sew_w  = 11'd8 << vsew;

  assign vill_d = (|vtype_raw[XLEN-1:8]) || (vlmul == 3'b100) || (sew_w > ELEN_L) ||
                  (frac && (sew_w > (ELEN_L >> fshift)));

  assign vlmax_base = VLEN_L >> (4'd3 + {1'b0, vsew});
  assign vlmax      = frac ? (vlmax_base >> fshift) : (vlmax_base << vlmul[1:0]);

  // Full-width AVL compare so that oversized AVL values saturate to VLMAX.
  always_comb begin
    if (is_vsetivli)  avl = XLEN'(instr_q[19:15]);
    else if (!rs1_x0) avl = rs1_q;
    else if (!rd_x0)  avl = XLEN'(vlmax);
    else              avl = XLEN'(vl_q);
    vl_d = (avl > XLEN'(vlmax)) ? vlmax : avl[VLW-1:0];
    if (vill_d || (keep_vl && (vl_q > vlmax))) vl_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_rd_q      <= '0;
      instr_q        <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      vl_q           <= '0;
      vtype_q        <= '0;
      vill_q         <= 1'b1;
      vstart_q       <= '0;
    end else begin
      if (vstart_we_i) vstart_q <= vstart_wdata_i;
      unique case (state_q)
        IDLE: if (req_valid_i && req_ready_q) begin
          instr_q     <= req_instr_i;
          rs1_q       <= req_rs1_i;
          rs2_q       <= req_rs2_i;
          req_ready_q <= 1'b0;
          state_q     <= CALC;
        end
        CALC: begin
          state_q        <= RESP;
          resp_valid_q   <= 1'b1;
          resp_illegal_q <= !legal_d;
          resp_rd_q      <= '0;
          // A legal op's vstart clear overrides a simultaneous CSR write.
          if (legal_d) begin
            vill_q    <= vill_d || (keep_vl && (vl_q > vlmax));
            vtype_q   <= (vill_d || (keep_vl && (vl_q > vlmax))) ? 8'h00 : vtype_raw[7:0];
            vl_q      <= vl_d;
            resp_rd_q <= XLEN'(vl_d);
            vstart_q  <= '0;
          end
        end
        RESP: if (resp_ready_i) begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_illegal_o = resp_illegal_q;
  assign resp_rd_data_o = resp_rd_q;
  assign vl_o           = vl_q;
  assign vtype_o        = {vill_q, vtype_q};
  assign vstart_o       = vstart_q;
  assign vlenb_o        = XLEN'(VLEN / 8);
endmodule

// File: tb/tb_ara_vcfg_unit.sv
// Directed bench for ara_vcfg_unit at VLEN=4096, ELEN=64, XLEN=64.
module tb_ara_vcfg_unit;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_instr_i = '0;
  logic [63:0] req_rs1_i = '0;
  logic [63:0] req_rs2_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [63:0] resp_rd_data_o;
  logic        resp_illegal_o;
  logic        vstart_we_i = 1'b0;
  logic [11:0] vstart_wdata_i = '0;
  logic [12:0] vl_o;
  logic [8:0]  vtype_o;
  logic [11:0] vstart_o;
  logic [63:0] vlenb_o;

  int checks = 0;
  int errors = 0;

  ara_vcfg_unit #(.VLEN(4096), .ELEN(64), .XLEN(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_instr_i(req_instr_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rd_data_o(resp_rd_data_o),
    .resp_illegal_o(resp_illegal_o), .vstart_we_i(vstart_we_i), .vstart_wdata_i(vstart_wdata_i),
    .vl_o(vl_o), .vtype_o(vtype_o), .vstart_o(vstart_o), .vlenb_o(vlenb_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction

  // Issues one op; lat = clock edges from accept to resp_valid_o (-1 on timeout).
  task automatic do_op(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [63:0] rd, output logic ill);
    int n;
    lat = -1; rd = '0; ill = 1'b0; n = 0;
    while (!req_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
    @(negedge clk_i);
    req_valid_i = 1'b1; req_instr_i = ins; req_rs1_i = a; req_rs2_i = b;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (!resp_valid_o && n < 10) begin @(posedge clk_i); #1; n++; end
    if (resp_valid_o) begin lat = n; rd = resp_rd_data_o; ill = resp_illegal_o; end
    if (resp_ready_i) begin @(posedge clk_i); #1; end
  endtask

  task automatic test_reset;
    checks += 8;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", req_ready_o); end
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", resp_valid_o); end
    if (resp_rd_data_o !== 64'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", resp_rd_data_o); end
    if (resp_illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b want 0", resp_illegal_o); end
    if (vl_o !== 13'd0) begin errors++; $display("FAIL reset_vl got %0d want 0", vl_o); end
    if (vtype_o !== 9'h100) begin errors++; $display("FAIL reset_vtype got %h want 100", vtype_o); end
    if (vstart_o !== 12'd0) begin errors++; $display("FAIL reset_vstart got %0d want 0", vstart_o); end
    if (vlenb_o !== 64'd512) begin errors++; $display("FAIL vlenb got %0d want 512", vlenb_o); end
  endtask

  task automatic test_vsetvli_basic;
    int lat; logic [63:0] rd; logic ill;
    do_op(enc_vsetvli(5'd5, 5'd6, 11'h010), 64'd100, 64'd0, lat, rd, ill);
    checks += 5;
    if (lat !== 1) begin errors++; $display("FAIL basic_latency got %0d want 1", lat); end
    if (rd !== 64'd100) begin errors++; $display("FAIL basic_rd got %0d want 100", rd); end
    if (ill !== 1'b0) begin errors++; $display("FAIL basic_illegal got %0b want 0", ill); end
    if (vl_o !== 13'd100) begin errors++; $display("FAIL basic_vl got %0d want 100", vl_o); end
    if (vtype_o !== 9'h010) begin errors++; $display("FAIL basic_vtype got %h want 010", vtype_o); end
  endtask

  task automatic test_vlmax;
    int lat; logic [63:0] rd; logic ill;
    do_op(enc_vsetvli(5'd1, 5'd0, 11'h003), 64'd5, 64'd0, lat, rd, ill);
    checks += 3;
    if (rd !== 64'd4096) begin errors++; $display("FAIL vlmax_x0_rd got %0d want 4096", rd); end
    if (vl_o !== 13'd4096) begin errors++; $display("FAIL vlmax_x0_vl got %0d want 4096", vl_o); end
    if (vtype_o !== 9'h003) begin errors++; $display("FAIL vlmax_x0_vtype got %h want 003", vtype_o); end
    do_op(enc_vsetvli(5'd1, 5'd6, 11'h003), 64'h100_0000_0000, 64'd0, lat, rd, ill);
    checks += 2;
    if (rd !== 64'd4096) begin errors++; $display("FAIL vlmax_huge_rd got %0d want 4096", rd); end
    if (vl_o !== 13'd4096) begin errors++; $display("FAIL vlmax_huge_vl got %0d want 4096", vl_o); end
  endtask

  task automatic test_vill;
    int lat; logic [63:0] rd; logic ill;
    do_op(enc_vsetivli(5'd2, 5'd31, 10'h018), 64'd0, 64'd0, lat, rd, ill);
    checks += 2;
    if (rd !== 64'd31) begin errors++; $display("FAIL ivli_e64m1_rd got %0d want 31", rd); end
    if (vtype_o !== 9'h018) begin errors++; $display("FAIL ivli_e64m1_vtype got %h want 018", vtype_o); end
    do_op(enc_vsetivli(5'd2, 5'd31, 10'h01F), 64'd0, 64'd0, lat, rd, ill);
    checks += 3;
    if (rd !== 64'd0) begin errors++; $display("FAIL ivli_e64mf2_rd got %0d want 0", rd); end
    if (vl_o !== 13'd0) begin errors++; $display("FAIL ivli_e64mf2_vl got %0d want 0", vl_o); end
    if (vtype_o !== 9'h100) begin errors++; $display("FAIL ivli_e64mf2_vtype got %h want 100", vtype_o); end
    do_op(enc_vsetivli(5'd2, 5'd8, 10'h012), 64'd0, 64'd0, lat, rd, ill);
    checks += 1;
    if (vl_o !== 13'd8) begin errors++; $display("FAIL ivli_e32m4_vl got %0d want 8", vl_o); end
    do_op(enc_vsetvli(5'd2, 5'd6, 11'h004), 64'd10, 64'd0, lat, rd, ill);
    checks += 2;
    if (vtype_o !== 9'h100) begin errors++; $display("FAIL lmul_rsvd_vtype got %h want 100", vtype_o); end
    if (vl_o !== 13'd0) begin errors++; $display("FAIL lmul_rsvd_vl got %0d want 0", vl_o); end
    do_op(enc_vsetivli(5'd2, 5'd8, 10'h012), 64'd0, 64'd0, lat, rd, ill);
    do_op(enc_vsetvli(5'd2, 5'd6, 11'h110), 64'd10, 64'd0, lat, rd, ill);
    checks += 2;
    if (vtype_o !== 9'h100) begin errors++; $display("FAIL rsvd_bit8_vtype got %h want 100", vtype_o); end
    if (rd !== 64'd0) begin errors++; $display("FAIL rsvd_bit8_rd got %0d want 0", rd); end
    do_op(enc_vsetvl(5'd2, 5'd6, 5'd7), 64'd10, 64'h8000_0000_0000_0010, lat, rd, ill);
    checks += 1;
    if (vtype_o !== 9'h100) begin errors++; $display("FAIL rsvd_bit63_vtype got %h want 100", vtype_o); end
  endtask

  task automatic test_keep_vl;
    int lat; logic [63:0] rd; logic ill;
    do_op(enc_vsetvli(5'd5, 5'd6, 11'h010), 64'd100, 64'd0, lat, rd, ill);
    do_op(enc_vsetvli(5'd0, 5'd0, 11'h009), 64'd7, 64'd0, lat, rd, ill);
    checks += 3;
    if (rd !== 64'd100) begin errors++; $display("FAIL keep_e16m2_rd got %0d want 100", rd); end
    if (vl_o !== 13'd100) begin errors++; $display("FAIL keep_e16m2_vl got %0d want 100", vl_o); end
    if (vtype_o !== 9'h009) begin errors++; $display("FAIL keep_e16m2_vtype got %h want 009", vtype_o); end
    do_op(enc_vsetvli(5'd0, 5'd0, 11'h005), 64'd7, 64'd0, lat, rd, ill);
    checks += 2;
    if (vtype_o !== 9'h100) begin errors++; $display("FAIL keep_e8mf8_vtype got %h want 100", vtype_o); end
    if (vl_o !== 13'd0) begin errors++; $display("FAIL keep_e8mf8_vl got %0d want 0", vl_o); end
    do_op(enc_vsetvli(5'd5, 5'd6, 11'h010), 64'd100, 64'd0, lat, rd, ill);
    do_op(enc_vsetvli(5'd0, 5'd0, 11'h01F), 64'd7, 64'd0, lat, rd, ill);
    checks += 2;
    if (vtype_o !== 9'h100) begin errors++; $display("FAIL keep_e64mf2_vtype got %h want 100", vtype_o); end
    if (vl_o !== 13'd0) begin errors++; $display("FAIL keep_e64mf2_vl got %0d want 0", vl_o); end
  endtask

  task automatic test_vstart_illegal;
    int lat; logic [63:0] rd; logic ill;
    @(negedge clk_i); vstart_we_i = 1'b1; vstart_wdata_i = 12'd7;
    @(negedge clk_i); vstart_we_i = 1'b0;
    checks += 1;
    if (vstart_o !== 12'd7) begin errors++; $display("FAIL vstart_write got %0d want 7", vstart_o); end
    do_op(enc_vsetvl(5'd5, 5'd6, 5'd7), 64'd10, 64'h10, lat, rd, ill);
    checks += 3;
    if (vstart_o !== 12'd0) begin errors++; $display("FAIL vsetvl_vstart got %0d want 0", vstart_o); end
    if (rd !== 64'd10) begin errors++; $display("FAIL vsetvl_rd got %0d want 10", rd); end
    if (vtype_o !== 9'h010) begin errors++; $display("FAIL vsetvl_vtype got %h want 010", vtype_o); end
    @(negedge clk_i); vstart_we_i = 1'b1; vstart_wdata_i = 12'd3;
    @(negedge clk_i); vstart_we_i = 1'b0;
    do_op({6'b0, 1'b1, 5'd2, 5'd3, 3'b000, 5'd4, 7'h57}, 64'd50, 64'd0, lat, rd, ill);
    checks += 5;
    if (ill !== 1'b1) begin errors++; $display("FAIL opivv_illegal got %0b want 1", ill); end
    if (rd !== 64'd0) begin errors++; $display("FAIL opivv_rd got %0d want 0", rd); end
    if (vl_o !== 13'd10) begin errors++; $display("FAIL opivv_vl got %0d want 10", vl_o); end
    if (vtype_o !== 9'h010) begin errors++; $display("FAIL opivv_vtype got %h want 010", vtype_o); end
    if (vstart_o !== 12'd3) begin errors++; $display("FAIL opivv_vstart got %0d want 3", vstart_o); end
    do_op({2'b10, 5'b00001, 5'd7, 5'd6, 3'b111, 5'd5, 7'h57}, 64'd50, 64'h08, lat, rd, ill);
    checks += 2;
    if (ill !== 1'b1) begin errors++; $display("FAIL cfg_rsvd_illegal got %0b want 1", ill); end
    if (vl_o !== 13'd10) begin errors++; $display("FAIL cfg_rsvd_vl got %0d want 10", vl_o); end
    // vstart write landing on the CALC->RESP edge of a legal op
    @(negedge clk_i); req_valid_i = 1'b1; req_instr_i = enc_vsetivli(5'd1, 5'd4, 10'h000);
    @(posedge clk_i); #1; req_valid_i = 1'b0; vstart_we_i = 1'b1; vstart_wdata_i = 12'd9;
    @(posedge clk_i); #1; vstart_we_i = 1'b0;
    checks += 2;
    if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL collide_valid got %0b want 1", resp_valid_o); end
    if (vstart_o !== 12'd0) begin errors++; $display("FAIL collide_vstart got %0d want 0", vstart_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back_hold;
    int lat; logic [63:0] rd; logic ill;
    resp_ready_i = 1'b0;
    do_op(enc_vsetivli(5'd3, 5'd5, 10'h000), 64'd0, 64'd0, lat, rd, ill);
    checks += 1;
    if (lat !== 1) begin errors++; $display("FAIL hold_latency got %0d want 1", lat); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checks += 3;
      if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %0b want 1", i, resp_valid_o); end
      if (resp_rd_data_o !== 64'd5) begin errors++; $display("FAIL hold_rd[%0d] got %0d want 5", i, resp_rd_data_o); end
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %0b want 0", i, req_ready_o); end
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checks += 2;
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL release_valid got %0b want 0", resp_valid_o); end
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got %0b want 1", req_ready_o); end
    do_op(enc_vsetivli(5'd3, 5'd17, 10'h008), 64'd0, 64'd0, lat, rd, ill);
    checks += 1;
    if (rd !== 64'd17) begin errors++; $display("FAIL b2b_rd got %0d want 17", rd); end
  endtask

  task automatic test_reset_mid;
    int seen;
    int lat; logic [63:0] rd; logic ill;
    do_op(enc_vsetvli(5'd5, 5'd6, 11'h010), 64'd100, 64'd0, lat, rd, ill);
    @(negedge clk_i); req_valid_i = 1'b1; req_instr_i = enc_vsetvli(5'd5, 5'd6, 11'h010); req_rs1_i = 64'd60;
    @(posedge clk_i); #1; req_valid_i = 1'b0;
    rst_i = 1'b1; #1;
    checks += 4;
    if (vl_o !== 13'd0) begin errors++; $display("FAIL rstmid_vl got %0d want 0", vl_o); end
    if (vtype_o !== 9'h100) begin errors++; $display("FAIL rstmid_vtype got %h want 100", vtype_o); end
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", resp_valid_o); end
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b want 1", req_ready_o); end
    @(negedge clk_i); rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk_i); #1; if (resp_valid_o) seen++; end
    checks += 2;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_noresp got %0d want 0", seen); end
    if (vl_o !== 13'd0) begin errors++; $display("FAIL rstmid_vl_after got %0d want 0", vl_o); end
  endtask

  initial begin
    #12;
    test_reset;
    @(negedge clk_i); rst_i = 1'b0;
    test_vsetvli_basic;
    test_vlmax;
    test_vill;
    test_keep_vl;
    test_vstart_illegal;
    test_back_to_back_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
